sc_player_move_ctrl: RTL and testbench

- Control stage directly upstream of the player-car point register.
- Converts raw left, right and start buttons plus the collision flag into the register's clear, load and shift-select strobes.
- Drives both register rows identically from one game FSM.
- Enforces debounce, a repeat-rate limit on movement, a crash hold-off, and a lives counter.

---
 rtl/sc_player_move_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_sc_player_move_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_player_move_ctrl.sv
// sc_player_move_ctrl
//
// Control stage in front of the player-car point register. Turns the raw
// start/left/right buttons and the collision flag into the register's clear,
// load and shift-select strobes. Both register rows are driven by these
// same outputs, so a single game FSM serves both.
//
// Ports:
//   SC_RegPOINTTYPE_CLOCK_50      system clock, rising edge
//   SC_RegPOINTTYPE_RESET_InHigh  asynchronous active-high reset
//   start_InLow / left_InLow / right_InLow
//                                 raw buttons, active-low, asynchronous
//   crash_In                      collision flag, synchronous, active-high
//   clear_OutLow                  one-cycle clear strobe on game start
//   load0_OutLow                  one-cycle respawn load strobe
//   load1_OutLow                  one-cycle game-over load strobe
//   shiftselection_Out            01 left, 10 right, 00 hold
//   lives_Out                     remaining lives
//   state_Out                     IDLE=0 INIT=1 PLAY=2 CRASH=3 GAMEOVER=4
module sc_player_move_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned MOVE_PERIOD     = 5000000,
  parameter int unsigned CRASH_CYCLES    = 50000000,
  parameter int unsigned LIVES           = 3
) (
  input  logic       SC_RegPOINTTYPE_CLOCK_50,
  input  logic       SC_RegPOINTTYPE_RESET_InHigh,
  input  logic       start_InLow,
  input  logic       left_InLow,
  input  logic       right_InLow,
  input  logic       crash_In,
  output logic       clear_OutLow,
  output logic       load0_OutLow,
  output logic       load1_OutLow,
  output logic [1:0] shiftselection_Out,
  output logic [2:0] lives_Out,
  output logic [2:0] state_Out
);

  // Counter widths sized to hold (N - 1), never narrower than one bit.
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned MvW = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int unsigned CrW = (CRASH_CYCLES > 1) ? $clog2(CRASH_CYCLES) : 1;

  localparam logic [DbW-1:0] DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [MvW-1:0] MvLast    = MvW'(MOVE_PERIOD - 1);
  localparam logic [CrW-1:0] CrLast    = CrW'(CRASH_CYCLES - 1);
  // The load strobe is registered, so it is launched one cycle before expiry
  // in order to be low during the final CRASH cycle.
  localparam logic [CrW-1:0] CrStrobe  = CrW'(CRASH_CYCLES - 2);
  localparam logic [2:0]     LivesInit = 3'(LIVES);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StInit     = 3'd1,
    StPlay     = 3'd2,
    StCrash    = 3'd3,
    StGameover = 3'd4
  } state_e;

  // Button index: 0 = start, 1 = left, 2 = right.
  localparam int unsigned NumBtn = 3;

  logic [NumBtn-1:0] raw;
  logic [NumBtn-1:0] sync1_q;
  logic [NumBtn-1:0] sync2_q;
  logic [NumBtn-1:0] db_q;
  logic [DbW-1:0]    db_cnt_q [NumBtn];
  logic              start_prev_q;

  assign raw = {right_InLow, left_InLow, start_InLow};

  // Two-flop synchronizer followed by a per-button stability counter. The
  // debounced level only follows the synchronized level once the two have
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; agreement at any point
  // restarts the count.
  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      db_q         <= '1;
      start_prev_q <= 1'b1;
      for (int i = 0; i < NumBtn; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q      <= raw;
      sync2_q      <= sync1_q;
      start_prev_q <= db_q[0];
      for (int i = 0; i < NumBtn; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbLast) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic       start_evt;
  logic       left_pressed;
  logic       right_pressed;
  logic [1:0] dir;

  // One-cycle pulse on the debounced press (1 -> 0) of start.
  assign start_evt     = start_prev_q & ~db_q[0];
  assign left_pressed  = ~db_q[1];
  assign right_pressed = ~db_q[2];

  // Exactly one direction held selects it; both or neither means hold.
  always_comb begin
    dir = 2'b00;
    if (left_pressed && !right_pressed) begin
      dir = 2'b01;
    end else if (right_pressed && !left_pressed) begin
      dir = 2'b10;
    end
  end

  state_e         state_q;
  logic [2:0]     lives_q;
  logic           clear_q;
  logic           load0_q;
  logic           load1_q;
  logic [1:0]     shift_q;
  logic [1:0]     prev_dir_q;
  logic [MvW-1:0] move_cnt_q;
  logic [CrW-1:0] crash_cnt_q;

  // Game FSM. All outputs are registered; strobes default inactive every
  // cycle so each one lasts exactly one cycle.
  always_ff @(posedge SC_RegPOINTTYPE_CLOCK_50 or posedge SC_RegPOINTTYPE_RESET_InHigh) begin
    if (SC_RegPOINTTYPE_RESET_InHigh) begin
      state_q     <= StIdle;
      lives_q     <= 3'd0;
      clear_q     <= 1'b1;
      load0_q     <= 1'b1;
      load1_q     <= 1'b1;
      shift_q     <= 2'b00;
      prev_dir_q  <= 2'b00;
      move_cnt_q  <= '0;
      crash_cnt_q <= '0;
    end else begin
      clear_q <= 1'b1;
      load0_q <= 1'b1;
      load1_q <= 1'b1;
      shift_q <= 2'b00;

      unique case (state_q)
        StIdle: begin
          if (start_evt) begin
            state_q <= StInit;
            clear_q <= 1'b0;
          end
        end

        StInit: begin
          lives_q    <= LivesInit;
          move_cnt_q <= '0;
          prev_dir_q <= 2'b00;
          state_q    <= StPlay;
        end

        StPlay: begin
          if (crash_In) begin
            // Crash wins over any shift due this cycle.
            state_q     <= StCrash;
            lives_q     <= (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;
            crash_cnt_q <= '0;
            move_cnt_q  <= '0;
            prev_dir_q  <= 2'b00;
          end else begin
            prev_dir_q <= dir;
            if (dir == 2'b00) begin
              move_cnt_q <= '0;
            end else if (dir != prev_dir_q) begin
              // New press, including a direct swap of direction.
              shift_q    <= dir;
              move_cnt_q <= '0;
            end else if (move_cnt_q == MvLast) begin
              shift_q    <= dir;
              move_cnt_q <= '0;
            end else begin
              move_cnt_q <= move_cnt_q + 1'b1;
            end
          end
        end

        StCrash: begin
          if (crash_cnt_q == CrLast) begin
            crash_cnt_q <= '0;
            state_q     <= (lives_q != 3'd0) ? StPlay : StGameover;
          end else begin
            crash_cnt_q <= crash_cnt_q + 1'b1;
            if (crash_cnt_q == CrStrobe) begin
              if (lives_q != 3'd0) begin
                load0_q <= 1'b0;
              end else begin
                load1_q <= 1'b0;
              end
            end
          end
        end

        StGameover: begin
          if (start_evt) begin
            state_q <= StInit;
            clear_q <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign clear_OutLow       = clear_q;
  assign load0_OutLow       = load0_q;
  assign load1_OutLow       = load1_q;
  assign shiftselection_Out = shift_q;
  assign lives_Out          = lives_q;
  assign state_Out          = state_q;

endmodule

// File: tb/tb_sc_player_move_ctrl.sv
// Testbench for sc_player_move_ctrl. A behavioural game model runs alongside
// the DUT and every output is compared each cycle, plus directed checks for
// the scenario milestones.
module tb_sc_player_move_ctrl;

  localparam int unsigned DB    = 4;
  localparam int unsigned MOVE  = 10;
  localparam int unsigned CRASH = 20;
  localparam int unsigned NLIV  = 2;

  logic       clk;
  logic       rst;
  logic       start_n;
  logic       left_n;
  logic       right_n;
  logic       crash;
  logic       clear_n;
  logic       load0_n;
  logic       load1_n;
  logic [1:0] shift;
  logic [2:0] lives;
  logic [2:0] state;

  sc_player_move_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .MOVE_PERIOD    (MOVE),
    .CRASH_CYCLES   (CRASH),
    .LIVES          (NLIV)
  ) dut (
    .SC_RegPOINTTYPE_CLOCK_50    (clk),
    .SC_RegPOINTTYPE_RESET_InHigh(rst),
    .start_InLow                 (start_n),
    .left_InLow                  (left_n),
    .right_InLow                 (right_n),
    .crash_In                    (crash),
    .clear_OutLow                (clear_n),
    .load0_OutLow                (load0_n),
    .load1_OutLow                (load1_n),
    .shiftselection_Out          (shift),
    .lives_Out                   (lives),
    .state_Out                   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- reference model ----------------
  // Button conditioning: raw level reaches the debouncer two edges later; the
  // debounced level flips once the last DB samples seen all disagree with it.
  bit        m_p1 [3];
  bit        m_p2 [3];
  bit        m_deb [3];
  bit [31:0] m_hist [3];
  int        m_nseen [3];
  bit        m_start_prev;
  // Game: state code, lives, pending strobes/shift, held direction, timers.
  int        m_state;
  int        m_lives;
  bit        e_clear;
  bit        e_load0;
  bit        e_load1;
  int        e_shift;
  int        m_held;
  int        m_since;
  int        m_crash_t;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_p1[i] = 1; m_p2[i] = 1; m_deb[i] = 1; m_hist[i] = 0; m_nseen[i] = 0;
    end
    m_start_prev = 1;
    m_state = 0; m_lives = 0;
    e_clear = 1; e_load0 = 1; e_load1 = 1; e_shift = 0;
    m_held = 0; m_since = 0; m_crash_t = 0;
  endtask

  task automatic model_edge();
    bit old_deb [3];
    bit raw [3];
    bit evt;
    bit l;
    bit r;
    int d;
    bit [31:0] mask;
    raw[0] = start_n; raw[1] = left_n; raw[2] = right_n;
    for (int i = 0; i < 3; i++) old_deb[i] = m_deb[i];
    evt = m_start_prev && !old_deb[0];

    e_clear = 1; e_load0 = 1; e_load1 = 1; e_shift = 0;
    case (m_state)
      0, 4: if (evt) begin m_state = 1; e_clear = 0; end
      1: begin m_lives = NLIV; m_state = 2; m_held = 0; m_since = 0; end
      2: begin
        if (crash) begin
          m_state = 3;
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_crash_t = 0;
          m_held = 0;
          m_since = 0;
        end else begin
          l = !old_deb[1];
          r = !old_deb[2];
          d = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
          if (d == 0) m_since = 0;
          else if (d != m_held) begin e_shift = d; m_since = 0; end
          else begin
            m_since++;
            if (m_since == MOVE) begin e_shift = d; m_since = 0; end
          end
          m_held = d;
        end
      end
      3: begin
        m_crash_t++;
        if (m_crash_t == CRASH) m_state = (m_lives != 0) ? 2 : 4;
        else if (m_crash_t == CRASH - 1) begin
          if (m_lives != 0) e_load0 = 0;
          else e_load1 = 0;
        end
      end
      default: m_state = 0;
    endcase

    mask = (32'd1 << DB) - 32'd1;
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][30:0], m_p2[i]};
      m_nseen[i]++;
      if (m_nseen[i] >= DB && (m_hist[i] & mask) == (old_deb[i] ? 32'd0 : mask))
        m_deb[i] = !old_deb[i];
      m_p2[i] = m_p1[i];
      m_p1[i] = raw[i];
    end
    m_start_prev = old_deb[0];
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("clear", clear_n, e_clear);
    check("load0", load0_n, e_load0);
    check("load1", load1_n, e_load1);
    check("shift", shift, e_shift[7:0]);
    check("lives", lives, m_lives[7:0]);
    check("state", state, m_state[7:0]);
  endtask

  // Counters of observed strobes/pulses for directed scenario checks.
  int n_clear;
  int n_load0;
  int n_load1;
  int n_left;
  int n_right;

  task automatic clear_counts();
    n_clear = 0; n_load0 = 0; n_load1 = 0; n_left = 0; n_right = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (!clear_n) n_clear++;
    if (!load0_n) n_load0++;
    if (!load1_n) n_load1++;
    if (shift == 2'b01) n_left++;
    if (shift == 2'b10) n_right++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int hold [3];
  bit found;

  initial begin
    rst = 1'b1; start_n = 1'b1; left_n = 1'b1; right_n = 1'b1; crash = 1'b0;
    model_reset();
    clear_counts();
    #2;
    check("reset_clear", clear_n, 1);
    check("reset_load0", load0_n, 1);
    check("reset_load1", load1_n, 1);
    check("reset_shift", shift, 0);
    check("reset_lives", lives, 0);
    check("reset_state", state, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    // Start the game.
    ticks(3);
    start_n = 1'b0;
    ticks(10);
    start_n = 1'b1;
    ticks(10);
    check("start_clear_pulses", n_clear[7:0], 1);
    check("start_other_strobes", 8'(n_load0 + n_load1), 0);
    check("start_state_play", state, 2);
    check("start_lives", lives, NLIV);

    // Hold left for 35 cycles: four left pulses, no right pulse.
    clear_counts();
    left_n = 1'b0;
    ticks(35);
    left_n = 1'b1;
    ticks(15);
    check("hold_left_pulses", n_left[7:0], 4);
    check("hold_left_no_right", n_right[7:0], 0);

    // Both pressed together: no movement.
    clear_counts();
    left_n = 1'b0; right_n = 1'b0;
    ticks(20);
    left_n = 1'b1; right_n = 1'b1;
    ticks(10);
    check("both_no_shift", 8'(n_left + n_right), 0);

    // Short glitch on right is filtered.
    clear_counts();
    right_n = 1'b0;
    ticks(2);
    right_n = 1'b1;
    ticks(12);
    check("glitch_no_shift", 8'(n_left + n_right), 0);

    // Right held 6 cycles: exactly one right pulse.
    clear_counts();
    right_n = 1'b0;
    ticks(6);
    right_n = 1'b1;
    ticks(15);
    check("right6_pulses", n_right[7:0], 1);
    check("right6_no_left", n_left[7:0], 0);

    // Crash in the cycle a repeated left pulse is due.
    left_n = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (shift == 2'b01) found = 1;
    end
    check("crash_first_pulse_seen", found, 1);
    ticks(MOVE - 1);
    crash = 1'b1;
    tick();
    crash = 1'b0;
    left_n = 1'b1;
    check("crash_shift_blocked", shift, 0);
    check("crash_state", state, 3);
    check("crash_lives", lives, 1);
    clear_counts();
    ticks(CRASH);
    check("respawn_load0", n_load0[7:0], 1);
    check("respawn_no_load1", n_load1[7:0], 0);
    check("respawn_state", state, 2);

    // Second crash: game over.
    ticks(10);
    crash = 1'b1;
    tick();
    crash = 1'b0;
    check("crash2_lives", lives, 0);
    clear_counts();
    ticks(CRASH);
    check("gameover_load1", n_load1[7:0], 1);
    check("gameover_no_load0", n_load0[7:0], 0);
    check("gameover_state", state, 4);
    for (int i = 0; i < 3; i++) begin
      crash = 1'b1; tick(); crash = 1'b0; ticks(3);
    end
    check("gameover_holds", state, 4);
    check("gameover_lives0", lives, 0);

    // Restart from game over.
    clear_counts();
    start_n = 1'b0;
    ticks(10);
    start_n = 1'b1;
    ticks(10);
    check("restart_clear", n_clear[7:0], 1);
    check("restart_state", state, 2);
    check("restart_lives", lives, NLIV);

    // Reset mid-CRASH (7th crash cycle).
    crash = 1'b1;
    tick();
    crash = 1'b0;
    ticks(6);
    check("pre_reset_state", state, 3);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check("midreset_clear", clear_n, 1);
    check("midreset_load0", load0_n, 1);
    check("midreset_load1", load1_n, 1);
    check("midreset_shift", shift, 0);
    check("midreset_lives", lives, 0);
    check("midreset_state", state, 0);
    #1 rst = 1'b0;
    clear_counts();
    ticks(30);
    check("post_reset_no_strobe", 8'(n_clear + n_load0 + n_load1), 0);
    check("post_reset_idle", state, 0);

    // Randomized buttons and crashes against the model.
    for (int i = 0; i < 3; i++) hold[i] = $urandom_range(1, 12);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          case (i)
            0: start_n = ~start_n;
            1: left_n  = ~left_n;
            default: right_n = ~right_n;
          endcase
          hold[i] = $urandom_range(1, 14);
        end else begin
          hold[i]--;
        end
      end
      crash = ($urandom_range(0, 24) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
